bus_slave_responder: RTL

Generic bus slave responder for the shared CPU bus. It sits behind the slave-side address decoder and answers the address, strobe, read/write and write-data phase issued by the granted master. It holds a small 32-bit register bank and inserts a configurable number of wait states. It returns the ready strobe and read data to the bus master.

---
 rtl/bus_slave_responder_pkg.sv | 25 ++
 rtl/bus_slave_responder_if.sv | 17 +
 rtl/bus_slave_regbank.sv | 31 +++
 rtl/bus_slave_responder.sv | 109 ++++++++++
 4 files changed

// File: rtl/bus_slave_responder_pkg.sv
// Shared CPU-bus definitions: widths, strobe polarities, slave FSM encoding
// and the request decode used by every slave on the bus.
package bus_slave_responder_pkg;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  typedef logic [BUS_ADDR_W-1:0] bus_addr_t;
  typedef logic [BUS_DATA_W-1:0] bus_data_t;

  function automatic logic bus_req(input logic cs_, input logic as_);
    return (cs_ == ENABLE_) && (as_ == ENABLE_);
  endfunction

endpackage

// File: rtl/bus_slave_responder_if.sv
// Slave-side view of the shared CPU bus: request phase from the master,
// ready strobe and read data back.
interface bus_slave_responder_if;
  import bus_slave_responder_pkg::*;

  logic      cs_;
  logic      as_;
  logic      rw;
  bus_addr_t addr;
  bus_data_t wr_data;
  bus_data_t rd_data;
  logic      rdy_;

  modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_);
  modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_);

endinterface

// File: rtl/bus_slave_regbank.sv
// DEPTH x 32 register array with one write port, a combinational read port
// and a permanent tap on register 0.
module bus_slave_regbank
  import bus_slave_responder_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  bus_data_t        wdata_i,
  output bus_data_t        rdata_o,
  output bus_data_t        reg0_o
);

  bus_data_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];
  assign reg0_o  = mem_q[0];

endmodule

// File: rtl/bus_slave_responder.sv
// Bus slave: accepts one access at a time, inserts WAIT_CYCLES wait states,
// then issues a registered one-cycle rdy_ with registered read data.
module bus_slave_responder
  import bus_slave_responder_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset_,
  bus_slave_responder_if.slave   bus,
  output bus_data_t              reg0_q
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  bus_addr_t  addr_q, addr_d;
  logic       rw_q, rw_d;
  bus_data_t  wdata_q, wdata_d;
  logic       rdy_q, rdy_d;
  bus_data_t  rd_data_q, rd_data_d;

  logic             req;
  logic [IDX_W-1:0] idx;
  logic             oor;
  logic             acc_rw;
  logic             we;
  bus_data_t        rd_word;

  // In IDLE the live bus is decoded so a zero-wait read can register its data
  // on the accepting edge; afterwards only the latched request matters.
  assign req    = bus_req(bus.cs_, bus.as_);
  assign idx    = (state_q == IDLE) ? bus.addr[IDX_W-1:0] : addr_q[IDX_W-1:0];
  assign oor    = (state_q == IDLE) ? (|bus.addr[BUS_ADDR_W-1:IDX_W])
                                    : (|addr_q[BUS_ADDR_W-1:IDX_W]);
  assign acc_rw = (state_q == IDLE) ? bus.rw : rw_q;
  assign we     = (state_q == ACK) && (rw_q == BUS_WRITE) && !oor;

  bus_slave_regbank #(.DEPTH(DEPTH)) u_regbank (
    .clk     (clk),
    .reset_  (reset_),
    .we_i    (we),
    .idx_i   (idx),
    .wdata_i (wdata_q),
    .rdata_o (rd_word),
    .reg0_o  (reg0_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.addr;
          rw_d    = bus.rw;
          wdata_d = bus.wr_data;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d     = (state_d == ACK) ? ENABLE_ : DISABLE_;
    rd_data_d = ((state_d == ACK) && (acc_rw == BUS_READ) && !oor) ? rd_word : '0;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rdy_q     <= DISABLE_;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rdy_q     <= rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rdy_    = rdy_q;
  assign bus.rd_data = rd_data_q;

endmodule
